beat_judge: RTL and testbench
=============================

Name: beat_judge

Overview:
- Downstream consumer of the game clock's beat pulses.
- Opens a hit window on each early pulse and closes it on the matching beat pulse.
- Judges the player's key presses against that window and keeps score, combo and lives.
- Drives the speed-reset request back to the clock when a game starts, and flags game over to the display logic.

Parameters:
LIVES_INIT, 3, lives loaded at game start (1..7)
SCORE_W, 10, score counter width
COMBO_W, 6, combo counter width

Ports:
CLOCK_50  input  1  system clock, all logic on rising edge
RESET  input  1  asynchronous, active-high reset
PULSE  input  1  one-cycle beat pulse from game clock
PULSE_EARLY  input  1  one-cycle early pulse from game clock, precedes PULSE
KEY  input  1  player key level, active-high, already synchronised
START  input  1  start request level, active-high
SCORE  output  SCORE_W  hits scored this game
COMBO  output  COMBO_W  consecutive hits
LIVES  output  3  remaining lives
HIT  output  1  one-cycle pulse per judged hit
MISS  output  1  one-cycle pulse per judged miss
SPEED_RESET  output  1  one-cycle pulse to game clock key_press input
PLAYING  output  1  high in ARMED/WINDOW/HELD
GAME_OVER  output  1  high in OVER

Behaviour:
Interface:
- One clock; reset is asynchronous and active-high.
- Clock port is CLOCK_50; reset port is RESET.

Reset values:
- state=IDLE.
- SCORE=0, COMBO=0, LIVES=LIVES_INIT.
- HIT, MISS, SPEED_RESET, PLAYING and GAME_OVER all 0.
- key_q=0, start_q=0, spent=0.

Edge detection:
- key_edge = KEY & ~key_q.
- start_edge = START & ~start_q.
- key_q and start_q are registered every cycle.
- All outputs are registered; HIT/MISS appear 1 cycle after the causing input sample.

States:
- IDLE: start_edge -> ARMED. Load SCORE=0, COMBO=0, LIVES=LIVES_INIT, spent=0; pulse SPEED_RESET.
- ARMED:
  - PULSE_EARLY -> WINDOW; clear spent.
  - key_edge with spent=0: early press. MISS, COMBO=0, LIVES-1, spent=1; stay ARMED.
  - key_edge with spent=1: ignored.
  - PULSE: ignored.
- WINDOW:
  - key_edge -> HELD. HIT, SCORE+1 (saturate at all-ones), COMBO+1 (saturate at all-ones).
  - PULSE without key_edge -> ARMED. MISS, COMBO=0, LIVES-1.
  - key_edge and PULSE in the same cycle: counts as a hit -> ARMED.
- HELD:
  - Further key_edge ignored.
  - PULSE -> ARMED.
- OVER:
  - GAME_OVER=1; SCORE/COMBO/LIVES frozen.
  - start_edge behaves as in IDLE -> ARMED.

Lives and game over:
- Any miss that takes LIVES from 1 to 0 goes to OVER on that same edge (MISS still pulses).
- LIVES never wraps below 0.

Simultaneous events:
- PULSE_EARLY and PULSE together in ARMED -> WINDOW.
- PULSE_EARLY and PULSE together in WINDOW: judge PULSE first (miss if no key_edge), then remain in WINDOW.
- PULSE_EARLY in HELD -> WINDOW (new beat); no judgement.
- key_edge and PULSE_EARLY together in ARMED: PULSE_EARLY wins (-> WINDOW); the key is then judged in WINDOW on the next edge only if it rises again.

Start during play:
- start_edge in ARMED/WINDOW/HELD restarts the game: same loads as from IDLE, -> ARMED.

Reset mid-game:
- Immediately returns all state to reset values; no HIT/MISS emitted.

Test Plan:
1. Release RESET, pulse START -> SPEED_RESET high exactly 1 cycle; PLAYING=1, LIVES=3, SCORE=0.
2. PULSE_EARLY, KEY rise 100 cycles later, PULSE 255 cycles after PULSE_EARLY -> one HIT; SCORE=1, COMBO=1, LIVES=3; a second KEY rise before PULSE does nothing.
3. PULSE_EARLY then PULSE with no KEY -> MISS on the cycle after PULSE; COMBO=0, LIVES=2.
4. Two KEY rises in ARMED before any PULSE_EARLY -> exactly one MISS; LIVES drops by 1 only.
5. Three misses from LIVES=3 -> GAME_OVER=1 after the third MISS; later PULSE/KEY leave SCORE unchanged; START -> ARMED, LIVES=3.
6. 1025 consecutive hits with SCORE_W=10 -> SCORE holds at 1023, COMBO holds at 63. Assert RESET mid-WINDOW -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/beat_judge.sv
// Hit-window judge for the rhythm game: opens a window on each early beat pulse,
// scores key presses against it and tracks score, combo and lives.
module beat_judge #(
    parameter int LIVES_INIT = 3,
    parameter int SCORE_W    = 10,
    parameter int COMBO_W    = 6
) (
    input  logic               CLOCK_50,
    input  logic               RESET,
    input  logic               PULSE,
    input  logic               PULSE_EARLY,
    input  logic               KEY,
    input  logic               START,
    output logic [SCORE_W-1:0] SCORE,
    output logic [COMBO_W-1:0] COMBO,
    output logic [2:0]         LIVES,
    output logic               HIT,
    output logic               MISS,
    output logic               SPEED_RESET,
    output logic               PLAYING,
    output logic               GAME_OVER
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_WINDOW,
        S_HELD,
        S_OVER
    } state_t;

    localparam logic [2:0] LIVES_LOAD = 3'(LIVES_INIT);

    state_t             state, state_n;
    logic               key_q, start_q;
    logic               spent, spent_n;
    logic [SCORE_W-1:0] score_n;
    logic [COMBO_W-1:0] combo_n;
    logic [2:0]         lives_n;
    logic               hit_n, miss_n, speed_reset_n;
    logic               miss_event;

    logic key_edge, start_edge;
    assign key_edge   = KEY & ~key_q;
    assign start_edge = START & ~start_q;

    // NOTE: every signal written here gets a default first, otherwise the
    // paths that do not assign it would infer a latch.
    always_comb begin
        state_n       = state;
        spent_n       = spent;
        score_n       = SCORE;
        combo_n       = COMBO;
        lives_n       = LIVES;
        hit_n         = 1'b0;
        miss_n        = 1'b0;
        speed_reset_n = 1'b0;
        miss_event    = 1'b0;

        if (start_edge) begin
            // A start edge (re)starts the game from any state.
            state_n       = S_ARMED;
            score_n       = '0;
            combo_n       = '0;
            lives_n       = LIVES_LOAD;
            spent_n       = 1'b0;
            speed_reset_n = 1'b1;
        end else begin
            case (state)
                S_ARMED: begin
                    if (PULSE_EARLY) begin
                        state_n = S_WINDOW;
                        spent_n = 1'b0;
                    end else if (key_edge && !spent) begin
                        // Press before the window opened: penalise once per beat.
                        miss_event = 1'b1;
                        spent_n    = 1'b1;
                    end
                end

                S_WINDOW: begin
                    if (key_edge) begin
                        hit_n   = 1'b1;
                        score_n = (&SCORE) ? SCORE : SCORE + 1'b1;
                        combo_n = (&COMBO) ? COMBO : COMBO + 1'b1;
                        if (PULSE_EARLY)
                            state_n = S_WINDOW;
                        else if (PULSE)
                            state_n = S_ARMED;
                        else
                            state_n = S_HELD;
                    end else if (PULSE) begin
                        miss_event = 1'b1;
                        state_n    = PULSE_EARLY ? S_WINDOW : S_ARMED;
                    end
                    if (PULSE_EARLY)
                        spent_n = 1'b0;
                end

                S_HELD: begin
                    if (PULSE_EARLY) begin
                        state_n = S_WINDOW;
                        spent_n = 1'b0;
                    end else if (PULSE) begin
                        state_n = S_ARMED;
                    end
                end

                default: ;
            endcase

            if (miss_event) begin
                miss_n  = 1'b1;
                combo_n = '0;
                if (LIVES != 3'd0)
                    lives_n = LIVES - 3'd1;
                if (LIVES <= 3'd1)
                    state_n = S_OVER;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state       <= S_IDLE;
            key_q       <= 1'b0;
            start_q     <= 1'b0;
            spent       <= 1'b0;
            SCORE       <= '0;
            COMBO       <= '0;
            LIVES       <= LIVES_LOAD;
            HIT         <= 1'b0;
            MISS        <= 1'b0;
            SPEED_RESET <= 1'b0;
            PLAYING     <= 1'b0;
            GAME_OVER   <= 1'b0;
        end else begin
            state       <= state_n;
            key_q       <= KEY;
            start_q     <= START;
            spent       <= spent_n;
            SCORE       <= score_n;
            COMBO       <= combo_n;
            LIVES       <= lives_n;
            HIT         <= hit_n;
            MISS        <= miss_n;
            SPEED_RESET <= speed_reset_n;
            // Status flags follow the next state so they line up with it.
            PLAYING     <= (state_n == S_ARMED) || (state_n == S_WINDOW) ||
                           (state_n == S_HELD);
            GAME_OVER   <= (state_n == S_OVER);
        end
    end

endmodule

// File: tb/tb_beat_judge.sv
// Self-checking bench for beat_judge: directed game scenarios followed by random
// beat/key traffic, all compared against a beat-level reference model.
module tb_beat_judge;

    localparam int LIVES_INIT = 3;
    localparam int SCORE_W    = 10;
    localparam int COMBO_W    = 6;
    localparam int SCORE_MAX  = (1 << SCORE_W) - 1;
    localparam int COMBO_MAX  = (1 << COMBO_W) - 1;

    logic               CLOCK_50 = 1'b0;
    logic               RESET, PULSE, PULSE_EARLY, KEY, START;
    logic [SCORE_W-1:0] SCORE;
    logic [COMBO_W-1:0] COMBO;
    logic [2:0]         LIVES;
    logic               HIT, MISS, SPEED_RESET, PLAYING, GAME_OVER;

    beat_judge #(
        .LIVES_INIT(LIVES_INIT),
        .SCORE_W   (SCORE_W),
        .COMBO_W   (COMBO_W)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .RESET      (RESET),
        .PULSE      (PULSE),
        .PULSE_EARLY(PULSE_EARLY),
        .KEY        (KEY),
        .START      (START),
        .SCORE      (SCORE),
        .COMBO      (COMBO),
        .LIVES      (LIVES),
        .HIT        (HIT),
        .MISS       (MISS),
        .SPEED_RESET(SPEED_RESET),
        .PLAYING    (PLAYING),
        .GAME_OVER  (GAME_OVER)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_checks = 0;
    int n_fail   = 0;
    int hit_cnt  = 0;
    int miss_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a game is a sequence of beats; each beat has an open
    // window that accepts at most one scoring press.
    int m_score, m_combo, m_lives;
    bit m_play, m_over, m_open, m_used, m_spent, m_kprev, m_sprev;
    bit e_hit, e_miss, e_sr;

    task automatic model_step(input bit rst, input bit start, input bit early,
                              input bit pulse, input bit key);
        bit ke, se, miss_now;
        e_hit = 0; e_miss = 0; e_sr = 0;
        if (rst) begin
            m_score = 0; m_combo = 0; m_lives = LIVES_INIT;
            m_play = 0; m_over = 0; m_open = 0; m_used = 0; m_spent = 0;
            m_kprev = 0; m_sprev = 0;
            return;
        end
        ke = key && !m_kprev;
        se = start && !m_sprev;
        m_kprev = key;
        m_sprev = start;
        miss_now = 0;
        if (se) begin
            m_score = 0; m_combo = 0; m_lives = LIVES_INIT;
            m_play = 1; m_over = 0; m_open = 0; m_used = 0; m_spent = 0;
            e_sr = 1;
        end else if (m_play) begin
            if (m_open && !m_used && ke) begin
                e_hit   = 1;
                m_score = (m_score < SCORE_MAX) ? m_score + 1 : SCORE_MAX;
                m_combo = (m_combo < COMBO_MAX) ? m_combo + 1 : COMBO_MAX;
                m_used  = 1;
            end else if (m_open && !m_used && pulse) begin
                miss_now = 1;
            end else if (!m_open && !early && ke && !m_spent) begin
                miss_now = 1;
                m_spent  = 1;
            end
            if (pulse) begin
                m_open = 0; m_used = 0;
            end
            if (early) begin
                m_open = 1; m_used = 0; m_spent = 0;
            end
            if (miss_now) begin
                e_miss  = 1;
                m_combo = 0;
                if (m_lives > 0) m_lives--;
                if (m_lives == 0) begin
                    m_play = 0;
                    m_over = 1;
                end
            end
        end
    endtask

    // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic cyc(input bit rst, input bit start, input bit early,
                       input bit pulse, input bit key);
        @(negedge CLOCK_50);
        RESET = rst; START = start; PULSE_EARLY = early; PULSE = pulse; KEY = key;
        @(posedge CLOCK_50);
        model_step(rst, start, early, pulse, key);
        #1;
        check("score",       32'(SCORE),       32'(m_score));
        check("combo",       32'(COMBO),       32'(m_combo));
        check("lives",       32'(LIVES),       32'(m_lives));
        check("hit",         32'(HIT),         32'(e_hit));
        check("miss",        32'(MISS),        32'(e_miss));
        check("speed_reset", 32'(SPEED_RESET), 32'(e_sr));
        check("playing",     32'(PLAYING),     32'(m_play));
        check("game_over",   32'(GAME_OVER),   32'(m_over));
        hit_cnt  += int'(HIT);
        miss_cnt += int'(MISS);
    endtask

    task automatic idle(input int n, input bit key);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, key);
    endtask

    initial begin
        RESET = 1; START = 0; PULSE_EARLY = 0; PULSE = 0; KEY = 0;

        // Reset state
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        check("rst_lives", 32'(LIVES), 32'(LIVES_INIT));
        check("rst_playing", 32'(PLAYING), 0);

        // Game start: one-cycle speed reset
        idle(2, 0);
        cyc(0, 1, 0, 0, 0);
        check("start_sr", 32'(SPEED_RESET), 1);
        check("start_playing", 32'(PLAYING), 1);
        cyc(0, 0, 0, 0, 0);
        check("start_sr_one_cycle", 32'(SPEED_RESET), 0);

        // One hit inside a long window; a second press in the same beat is ignored
        hit_cnt = 0;
        cyc(0, 0, 1, 0, 0);
        for (int t = 1; t <= 255; t++)
            cyc(0, 0, 0, t == 255, (t >= 100 && t < 120) || t >= 130);
        cyc(0, 0, 0, 0, 0);
        check("one_hit", hit_cnt, 1);
        check("hit_score", 32'(SCORE), 1);
        check("hit_combo", 32'(COMBO), 1);
        check("hit_lives", 32'(LIVES), 3);

        // Window closes without a press
        cyc(0, 0, 1, 0, 0);
        idle(5, 0);
        cyc(0, 0, 0, 1, 0);
        check("late_miss", 32'(MISS), 1);
        check("late_miss_combo", 32'(COMBO), 0);
        check("late_miss_lives", 32'(LIVES), 2);

        // Two early presses in one armed period cost one life
        miss_cnt = 0;
        cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 0);
        idle(2, 0);
        check("early_one_miss", miss_cnt, 1);
        check("early_lives", 32'(LIVES), 1);

        // Restart, then three misses end the game
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        for (int b = 0; b < 3; b++) begin
            cyc(0, 0, 1, 0, 0);
            idle(3, 0);
            cyc(0, 0, 0, 1, 0);
        end
        check("over_flag", 32'(GAME_OVER), 1);
        check("over_lives", 32'(LIVES), 0);
        cyc(0, 0, 1, 0, 0); cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 1, 0); cyc(0, 0, 0, 0, 0);
        check("over_score_frozen", 32'(SCORE), 0);
        cyc(0, 1, 0, 0, 0);
        check("restart_playing", 32'(PLAYING), 1);
        check("restart_lives", 32'(LIVES), 3);
        cyc(0, 0, 0, 0, 0);

        // Saturation: 1025 consecutive hits
        for (int b = 0; b < 1025; b++) begin
            cyc(0, 0, 1, 0, 0);
            cyc(0, 0, 0, 0, 1);
            cyc(0, 0, 0, 0, 0);
            cyc(0, 0, 0, 1, 0);
        end
        check("score_sat", 32'(SCORE), 32'(SCORE_MAX));
        check("combo_sat", 32'(COMBO), 32'(COMBO_MAX));

        // Reset in the middle of a window
        cyc(0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 1);
        check("midrst_score", 32'(SCORE), 0);
        check("midrst_combo", 32'(COMBO), 0);
        check("midrst_lives", 32'(LIVES), 32'(LIVES_INIT));
        check("midrst_playing", 32'(PLAYING), 0);
        cyc(0, 0, 0, 0, 0);

        // Random beat/key traffic with occasional starts and resets
        begin
            bit k;
            k = 0;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 3) == 0) k = ~k;
                cyc($urandom_range(0, 799) == 0,
                    $urandom_range(0, 59) == 0,
                    $urandom_range(0, 7) == 0,
                    $urandom_range(0, 7) == 0,
                    k);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
